ap_cam_array: RTL and testbench

//  Parametrised CAM storage array for the associative processor (AP); successor to the single-bit-key cell array.

---
 rtl/ap_pkg.sv | 25 ++
 rtl/ap_match_reduce.sv | 31 +++
 rtl/ap_cam_array.sv | 182 ++++++++++++++++++
 tb/tb_ap_cam_array.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ap_pkg.sv
// Shared constants for the associative-processor CAM array: opcodes,
// tag-accumulation modes and command FSM state encodings.
package ap_pkg;

   // Command opcodes (3-bit, fully decoded)
   localparam logic [2:0] OP_NOP       = 3'd0;
   localparam logic [2:0] OP_WR_ROW    = 3'd1;
   localparam logic [2:0] OP_WR_COL    = 3'd2;
   localparam logic [2:0] OP_RD_ROW    = 3'd3;
   localparam logic [2:0] OP_RD_COL    = 3'd4;
   localparam logic [2:0] OP_COMPARE   = 3'd5;
   localparam logic [2:0] OP_WR_TAGGED = 3'd6;
   localparam logic [2:0] OP_TAG_ALL   = 3'd7;

   // COMPARE tag accumulation modes; code 3 is reserved and behaves as SET
   localparam logic [1:0] TAG_SET = 2'd0;
   localparam logic [1:0] TAG_AND = 2'd1;
   localparam logic [1:0] TAG_OR  = 2'd2;

   // Command FSM: one command in flight, IDLE -> EXEC -> RESP -> IDLE
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/ap_match_reduce.sv
// Tag vector reduction: any-match flag, lowest matching row index
// (priority encoder, 0 when nothing matches) and number of matching rows.
module ap_match_reduce #(
   parameter int DATA_DEPTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic [DATA_DEPTH-1:0] tag_i,
   output logic                  match_any_o,
   output logic [ADDR_WIDTH-1:0] match_first_o,
   output logic [ADDR_WIDTH-1:0] match_count_o
);

   // Single pass over the tag: first set bit wins the encoder, every set bit counts
   always_comb begin
      logic found;
      found         = 1'b0;
      match_first_o = '0;
      match_count_o = '0;
      for (int r = 0; r < DATA_DEPTH; r++) begin
         if (tag_i[r]) begin
            match_count_o = match_count_o + ADDR_WIDTH'(1);
            if (!found) begin
               match_first_o = ADDR_WIDTH'(r);
               found         = 1'b1;
            end
         end
      end
      match_any_o = found;
   end

endmodule

// File: rtl/ap_cam_array.sv
// CAM storage array for the associative processor. Executes one command at a
// time: row/column write and read, masked compare with tag accumulation and
// tag-driven masked parallel write.
//
// Handshake: a command is accepted on a rising clk edge where op_valid and
// op_ready are both 1; op_ready is 1 only in IDLE, and all op_* inputs are
// captured at that edge only. Each accepted command yields exactly one
// rsp_valid pulse two edges later; rsp_row/rsp_col/rsp_err are 0 outside it.
module ap_cam_array
   import ap_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DATA_DEPTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rstIn,
   input  logic                  op_valid,
   output logic                  op_ready,
   input  logic [2:0]            op_code,
   input  logic [ADDR_WIDTH-1:0] op_addr,
   input  logic [DATA_WIDTH-1:0] op_data,
   input  logic [DATA_DEPTH-1:0] op_col_data,
   input  logic [DATA_WIDTH-1:0] op_mask,
   input  logic [1:0]            op_tag_mode,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_row,
   output logic [DATA_DEPTH-1:0] rsp_col,
   output logic                  rsp_err,
   output logic [DATA_DEPTH-1:0] tag_row,
   output logic                  match_any,
   output logic [ADDR_WIDTH-1:0] match_first,
   output logic [ADDR_WIDTH-1:0] match_count,
   output logic [1:0]            dbg_state_o
);

   localparam int ARRAY_BITS = DATA_WIDTH * DATA_DEPTH;

   // FSM and latched command
   logic [1:0]            state_q, state_d;
   logic [2:0]            op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_DEPTH-1:0] col_q;
   logic [DATA_WIDTH-1:0] mask_q;
   logic [1:0]            mode_q;

   // Storage, tag and registered response
   logic [ARRAY_BITS-1:0] array_q, array_d;
   logic [DATA_DEPTH-1:0] tag_q, tag_d;
   logic [DATA_WIDTH-1:0] rsp_row_q, rsp_row_d;
   logic [DATA_DEPTH-1:0] rsp_col_q, rsp_col_d;
   logic                  rsp_err_q, rsp_err_d;

   logic [DATA_DEPTH-1:0] match_vec;
   logic                  row_ok, col_ok, accept;

   assign accept = (state_q == S_IDLE) && op_valid;
   assign row_ok = (32'(addr_q) < 32'(DATA_DEPTH));
   assign col_ok = (32'(addr_q) < 32'(DATA_WIDTH));

   // Per-row masked compare of the latched key against current contents
   always_comb begin
      for (int r = 0; r < DATA_DEPTH; r++)
         match_vec[r] = &(~(array_q[r*DATA_WIDTH +: DATA_WIDTH] ^ data_q) | ~mask_q);
   end

   // Next-state, array/tag update and response data; work happens only in EXEC
   always_comb begin
      state_d   = state_q;
      array_d   = array_q;
      tag_d     = tag_q;
      rsp_row_d = '0;
      rsp_col_d = '0;
      rsp_err_d = 1'b0;
      case (state_q)
         S_IDLE: if (op_valid) state_d = S_EXEC;
         S_EXEC: begin
            state_d = S_RESP;
            case (op_q)
               OP_WR_ROW: begin
                  if (!row_ok) rsp_err_d = 1'b1;
                  for (int r = 0; r < DATA_DEPTH; r++)
                     if (row_ok && addr_q == ADDR_WIDTH'(r))
                        array_d[r*DATA_WIDTH +: DATA_WIDTH] = data_q;
               end
               OP_WR_COL: begin
                  if (!col_ok) rsp_err_d = 1'b1;
                  for (int r = 0; r < DATA_DEPTH; r++)
                     for (int c = 0; c < DATA_WIDTH; c++)
                        if (col_ok && addr_q == ADDR_WIDTH'(c))
                           array_d[r*DATA_WIDTH + c] = col_q[r];
               end
               OP_RD_ROW: begin
                  if (!row_ok) rsp_err_d = 1'b1;
                  for (int r = 0; r < DATA_DEPTH; r++)
                     if (row_ok && addr_q == ADDR_WIDTH'(r))
                        rsp_row_d = array_q[r*DATA_WIDTH +: DATA_WIDTH];
               end
               OP_RD_COL: begin
                  if (!col_ok) rsp_err_d = 1'b1;
                  for (int r = 0; r < DATA_DEPTH; r++)
                     for (int c = 0; c < DATA_WIDTH; c++)
                        if (col_ok && addr_q == ADDR_WIDTH'(c))
                           rsp_col_d[r] = array_q[r*DATA_WIDTH + c];
               end
               OP_COMPARE: begin
                  case (mode_q)
                     TAG_AND: tag_d = tag_q & match_vec;
                     TAG_OR:  tag_d = tag_q | match_vec;
                     TAG_SET: tag_d = match_vec;
                     default: tag_d = match_vec;
                  endcase
               end
               OP_WR_TAGGED: begin
                  for (int r = 0; r < DATA_DEPTH; r++)
                     if (tag_q[r])
                        array_d[r*DATA_WIDTH +: DATA_WIDTH] =
                           (array_q[r*DATA_WIDTH +: DATA_WIDTH] & ~mask_q) | (data_q & mask_q);
               end
               OP_TAG_ALL: tag_d = '1;
               OP_NOP:     ;
               default:    ;
            endcase
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; command fields captured only at the accept edge
   always_ff @(posedge clk or negedge rstIn) begin
      if (!rstIn) begin
         state_q   <= S_IDLE;
         op_q      <= OP_NOP;
         addr_q    <= '0;
         data_q    <= '0;
         col_q     <= '0;
         mask_q    <= '0;
         mode_q    <= TAG_SET;
         array_q   <= '0;
         tag_q     <= '0;
         rsp_row_q <= '0;
         rsp_col_q <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         array_q   <= array_d;
         tag_q     <= tag_d;
         rsp_row_q <= rsp_row_d;
         rsp_col_q <= rsp_col_d;
         rsp_err_q <= rsp_err_d;
         if (accept) begin
            op_q   <= op_code;
            addr_q <= op_addr;
            data_q <= op_data;
            col_q  <= op_col_data;
            mask_q <= op_mask;
            mode_q <= op_tag_mode;
         end
      end
   end

   assign op_ready    = (state_q == S_IDLE);
   assign rsp_valid   = (state_q == S_RESP);
   assign rsp_row     = rsp_row_q;
   assign rsp_col     = rsp_col_q;
   assign rsp_err     = rsp_err_q;
   assign tag_row     = tag_q;
   assign dbg_state_o = state_q;

   ap_match_reduce #(
      .DATA_DEPTH (DATA_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_match_reduce (
      .tag_i         (tag_q),
      .match_any_o   (match_any),
      .match_first_o (match_first),
      .match_count_o (match_count)
   );

endmodule

// File: tb/tb_ap_cam_array.sv
// Bench for ap_cam_array (default 8 x 16 geometry).
module tb_ap_cam_array;
   import ap_pkg::*;

   typedef struct packed {
      logic [7:0]  row;
      logic [15:0] col;
      logic        err;
      logic [15:0] tag;
      logic        any;
      logic [7:0]  first;
      logic [7:0]  count;
   } exp_t;
   localparam int EW = $bits(exp_t);

   logic        clk = 1'b0;
   logic        rstIn;
   logic        op_valid;
   logic        op_ready;
   logic [2:0]  op_code;
   logic [7:0]  op_addr;
   logic [7:0]  op_data;
   logic [15:0] op_col_data;
   logic [7:0]  op_mask;
   logic [1:0]  op_tag_mode;
   logic        rsp_valid;
   logic [7:0]  rsp_row;
   logic [15:0] rsp_col;
   logic        rsp_err;
   logic [15:0] tag_row;
   logic        match_any;
   logic [7:0]  match_first;
   logic [7:0]  match_count;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_cyc = 0;

   logic [EW-1:0] exp_q[$];
   logic [7:0]    mdl[16];
   logic [15:0]   mdl_tag;

   ap_cam_array dut (
      .clk         (clk),
      .rstIn       (rstIn),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .op_code     (op_code),
      .op_addr     (op_addr),
      .op_data     (op_data),
      .op_col_data (op_col_data),
      .op_mask     (op_mask),
      .op_tag_mode (op_tag_mode),
      .rsp_valid   (rsp_valid),
      .rsp_row     (rsp_row),
      .rsp_col     (rsp_col),
      .rsp_err     (rsp_err),
      .tag_row     (tag_row),
      .match_any   (match_any),
      .match_first (match_first),
      .match_count (match_count),
      .dbg_state_o (dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // reference model: applies one command, returns expected response
   task automatic model_op(input logic [2:0] code, input logic [7:0] addr, input logic [7:0] data,
                           input logic [15:0] col, input logic [7:0] mask, input logic [1:0] mode,
                           output exp_t e);
      logic [15:0] m;
      e = '0;
      case (code)
         OP_WR_ROW: if (addr < 16) mdl[addr[3:0]] = data; else e.err = 1'b1;
         OP_WR_COL: if (addr < 8) begin
            for (int r = 0; r < 16; r++) mdl[r][addr[2:0]] = col[r];
         end else e.err = 1'b1;
         OP_RD_ROW: if (addr < 16) e.row = mdl[addr[3:0]]; else e.err = 1'b1;
         OP_RD_COL: if (addr < 8) begin
            for (int r = 0; r < 16; r++) e.col[r] = mdl[r][addr[2:0]];
         end else e.err = 1'b1;
         OP_COMPARE: begin
            for (int r = 0; r < 16; r++) m[r] = ((mdl[r] & mask) == (data & mask));
            if (mode == 2'd1)      mdl_tag = mdl_tag & m;
            else if (mode == 2'd2) mdl_tag = mdl_tag | m;
            else                   mdl_tag = m;
         end
         OP_WR_TAGGED: for (int r = 0; r < 16; r++)
            if (mdl_tag[r]) mdl[r] = (mdl[r] & ~mask) | (data & mask);
         OP_TAG_ALL: mdl_tag = 16'hFFFF;
         default: ;
      endcase
      e.tag = mdl_tag;
      e.any = |mdl_tag;
      for (int r = 15; r >= 0; r--) if (mdl_tag[r]) e.first = 8'(r);
      for (int r = 0; r < 16; r++) if (mdl_tag[r]) e.count = e.count + 8'd1;
   endtask

   task automatic model_reset();
      for (int r = 0; r < 16; r++) mdl[r] = 8'h00;
      mdl_tag = 16'h0;
      exp_q.delete();
   endtask

   // scoreboard: pop and compare on every response pulse
   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid) begin
         if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
         else begin
            e = exp_t'(exp_q.pop_front());
            chk("latency", 64'(cyc - acc_cyc), 2);
            chk("rsp_row", rsp_row, e.row);
            chk("rsp_col", rsp_col, e.col);
            chk("rsp_err", rsp_err, e.err);
            chk("tag_row", tag_row, e.tag);
            chk("match_any", match_any, e.any);
            chk("match_first", match_first, e.first);
            chk("match_count", match_count, e.count);
         end
      end else begin
         chk("idle_rsp_zero", {rsp_row, rsp_col, rsp_err}, 0);
      end
   end

   // driver: one command, waits for its response to be scored
   task automatic send_op(input logic [2:0] code, input logic [7:0] addr, input logic [7:0] data,
                          input logic [15:0] col, input logic [7:0] mask, input logic [1:0] mode);
      exp_t e;
      int n;
      n = 0;
      @(negedge clk);
      while (!op_ready && n < 20) begin @(negedge clk); n++; end
      if (!op_ready) begin chk("ready_timeout", 0, 1); return; end
      op_valid = 1'b1; op_code = code; op_addr = addr; op_data = data;
      op_col_data = col; op_mask = mask; op_tag_mode = mode;
      model_op(code, addr, data, col, mask, mode, e);
      exp_q.push_back(EW'(e));
      acc_cyc = cyc;
      @(negedge clk);
      op_valid = 1'b0;
      op_code = 3'($urandom); op_addr = 8'($urandom); op_data = 8'($urandom);
      op_col_data = 16'($urandom); op_mask = 8'($urandom);
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin @(posedge clk); #2; n++; end
      if (exp_q.size() != 0) begin chk("rsp_timeout", 0, 1); exp_q.delete(); end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstIn = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rstIn = 1'b1;
   endtask

   initial begin
      exp_t e;
      rstIn = 1'b0; op_valid = 1'b0; op_code = '0; op_addr = '0; op_data = '0;
      op_col_data = '0; op_mask = '0; op_tag_mode = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_op_ready", op_ready, 1);
      chk("rst_tag", tag_row, 0);
      chk("rst_match", {match_any, match_first, match_count}, 0);
      chk("rst_state", dbg_state, S_IDLE);
      rstIn = 1'b1;

      // 1: row write / read back
      send_op(OP_WR_ROW, 8'd3, 8'hA5, 16'h0, 8'h00, 2'd0);
      send_op(OP_RD_ROW, 8'd3, 8'h00, 16'h0, 8'h00, 2'd0);

      // 2: masked compare, SET
      send_op(OP_WR_ROW, 8'd0, 8'h10, 16'h0, 8'h00, 2'd0);
      send_op(OP_WR_ROW, 8'd1, 8'h1F, 16'h0, 8'h00, 2'd0);
      send_op(OP_WR_ROW, 8'd2, 8'h20, 16'h0, 8'h00, 2'd0);
      send_op(OP_WR_ROW, 8'd3, 8'h1A, 16'h0, 8'h00, 2'd0);
      send_op(OP_COMPARE, 8'd0, 8'h10, 16'h0, 8'hF0, TAG_SET);
      chk("t2_tag", tag_row, 16'h000B);
      chk("t2_count", match_count, 3);
      chk("t2_first", match_first, 0);

      // 3: AND then OR accumulation
      send_op(OP_COMPARE, 8'd0, 8'h0A, 16'h0, 8'h0F, TAG_AND);
      chk("t3_and_tag", tag_row, 16'h0008);
      chk("t3_and_first", match_first, 3);
      send_op(OP_COMPARE, 8'd0, 8'h20, 16'h0, 8'hFF, TAG_OR);
      chk("t3_or_tag", tag_row, 16'h000C);
      send_op(OP_COMPARE, 8'd0, 8'h00, 16'h0, 8'h00, 2'd3);
      chk("mask0_reserved_set", tag_row, 16'hFFFF);

      // 4: tag-all + tagged write on a zeroed array, then column reads
      do_reset();
      send_op(OP_TAG_ALL, 8'd0, 8'h00, 16'h0, 8'h00, 2'd0);
      send_op(OP_WR_TAGGED, 8'd0, 8'h0F, 16'h0, 8'h0F, 2'd0);
      send_op(OP_RD_COL, 8'd4, 8'h00, 16'h0, 8'h00, 2'd0);
      send_op(OP_RD_COL, 8'd0, 8'h00, 16'h0, 8'h00, 2'd0);
      send_op(OP_RD_ROW, 8'd15, 8'h00, 16'h0, 8'h00, 2'd0);
      send_op(OP_WR_COL, 8'd7, 8'h00, 16'h8001, 8'h00, 2'd0);
      send_op(OP_RD_ROW, 8'd0, 8'h00, 16'h0, 8'h00, 2'd0);
      send_op(OP_RD_COL, 8'd7, 8'h00, 16'h0, 8'h00, 2'd0);

      // 5: out-of-range addresses
      send_op(OP_RD_ROW, 8'd16, 8'h00, 16'h0, 8'h00, 2'd0);
      send_op(OP_WR_COL, 8'd8, 8'h00, 16'hFFFF, 8'h00, 2'd0);
      send_op(OP_WR_ROW, 8'd200, 8'h55, 16'h0, 8'h00, 2'd0);
      send_op(OP_RD_COL, 8'd8, 8'h00, 16'h0, 8'h00, 2'd0);
      send_op(OP_RD_ROW, 8'd1, 8'h00, 16'h0, 8'h00, 2'd0);
      chk("t5_err_on_valid_row", mdl[1], 8'h0F);

      // 6a: op_valid held through EXEC with changing data -> single accept
      @(negedge clk);
      op_valid = 1'b1; op_code = OP_WR_ROW; op_addr = 8'd6; op_data = 8'h3C;
      model_op(OP_WR_ROW, 8'd6, 8'h3C, 16'h0, 8'h00, 2'd0, e);
      exp_q.push_back(EW'(e));
      acc_cyc = cyc;
      @(negedge clk);
      chk("hold_exec_ready", op_ready, 0);
      chk("hold_exec_state", dbg_state, S_EXEC);
      op_data = 8'hFF;
      @(negedge clk);
      op_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("hold_queue_empty", 64'(exp_q.size()), 0);
      send_op(OP_RD_ROW, 8'd6, 8'h00, 16'h0, 8'h00, 2'd0);

      // 6b: reset during EXEC drops the command
      send_op(OP_TAG_ALL, 8'd0, 8'h00, 16'h0, 8'h00, 2'd0);
      @(negedge clk);
      op_valid = 1'b1; op_code = OP_WR_ROW; op_addr = 8'd5; op_data = 8'h77;
      acc_cyc = cyc;
      @(negedge clk);
      chk("rst_exec_state", dbg_state, S_EXEC);
      rstIn = 1'b0;
      model_reset();
      @(negedge clk);
      chk("midrst_valid", rsp_valid, 0);
      chk("midrst_ready", op_ready, 1);
      chk("midrst_tag", tag_row, 0);
      chk("midrst_match", {match_any, match_first, match_count}, 0);
      op_valid = 1'b0;
      rstIn = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_rst_ready", op_ready, 1);
      send_op(OP_RD_ROW, 8'd5, 8'h00, 16'h0, 8'h00, 2'd0);
      send_op(OP_RD_ROW, 8'd6, 8'h00, 16'h0, 8'h00, 2'd0);

      // random mix against the model
      for (int i = 0; i < 60; i++) begin
         send_op(3'($urandom_range(0, 7)), 8'($urandom_range(0, 19)), 8'($urandom),
                 16'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
